// File: rtl/nn_mac_pipe.sv
// Pipelined multiply-accumulate unit: NUM_STAGE product registers, an accumulate
// stage with optional saturation, and a registered result with valid/ready handshakes.
module nn_mac_pipe #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int SATURATE   = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_first,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  dout_ovf
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;
    localparam bit ACC_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam logic [ACC_WIDTH-1:0] MAX_VAL = ACC_SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}}
                                                          : {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] MIN_VAL = ACC_SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                          : {ACC_WIDTH{1'b0}};

    logic stall;
    logic advance;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ce & ~stall;
    assign advance  = ce & ~stall;

    // Low P bits of the product are exact for every signedness mix, so one multiplier serves all modes.
    logic [P-1:0] op0;
    logic [P-1:0] op1;
    logic [P-1:0] prod_c;

    always_comb begin
        if (SIGNED0 != 0) op0 = P'($signed(din0));
        else              op0 = P'(din0);
        if (SIGNED1 != 0) op1 = P'($signed(din1));
        else              op1 = P'(din1);
        prod_c = op0 * op1;
    end

    logic [P-1:0]         prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q;
    logic [NUM_STAGE-1:0] fst_q;
    logic [NUM_STAGE-1:0] lst_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
        end else if (advance) begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= in_valid;
            fst_q[0]  <= acc_first;
            lst_q[0]  <= acc_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                fst_q[i]  <= fst_q[i-1];
                lst_q[i]  <= lst_q[i-1];
            end
        end
    end

    logic [P-1:0]         t_prod;
    logic                 t_vld;
    logic                 t_fst;
    logic                 t_lst;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_w;
    logic                 add_ovf;
    logic [ACC_WIDTH-1:0] clamp;
    logic [ACC_WIDTH-1:0] add_res;
    logic                 grp_start;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_d;

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic                 open_q;
    logic                 res_pend_q;

    assign t_prod = prod_q[NUM_STAGE-1];
    assign t_vld  = vld_q[NUM_STAGE-1];
    assign t_fst  = fst_q[NUM_STAGE-1];
    assign t_lst  = lst_q[NUM_STAGE-1];

    // One extra bit on the add: carry for unsigned, sign disagreement for signed.
    always_comb begin
        if (ACC_SIGNED) begin
            prod_ext = ACC_WIDTH'($signed(t_prod));
            sum_w    = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
            add_ovf  = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
            clamp    = sum_w[ACC_WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            prod_ext = ACC_WIDTH'(t_prod);
            sum_w    = {1'b0, acc_q} + {1'b0, prod_ext};
            add_ovf  = sum_w[ACC_WIDTH];
            clamp    = MAX_VAL;
        end
        if (add_ovf && (SATURATE != 0)) add_res = clamp;
        else                            add_res = sum_w[ACC_WIDTH-1:0];
        grp_start = t_fst | ~open_q;
        acc_d     = grp_start ? prod_ext : add_res;
        ovf_d     = grp_start ? 1'b0 : (ovf_q | add_ovf);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            open_q     <= 1'b0;
            res_pend_q <= 1'b0;
        end else if (advance) begin
            res_pend_q <= t_vld & t_lst;
            if (t_vld) begin
                acc_q  <= acc_d;
                ovf_q  <= ovf_d;
                open_q <= ~t_lst;
            end
        end
    end

    // An advancing cycle always retires any held result, so out_valid simply follows res_pend_q.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_ovf  <= 1'b0;
        end else if (advance) begin
            out_valid <= res_pend_q;
            if (res_pend_q) begin
                dout     <= acc_q;
                dout_ovf <= ovf_q;
            end
        end
    end

endmodule
